lmdpl_tablegen_array: RTL
=========================

# lmdpl_tablegen_array

Parametrised, registered LUT-selector generator for a bank of `N_GATES` masked 2-input LMDPL gates, each with a runtime-selectable Boolean function. It collects fresh masks from the mask PRNG over a valid/ready stream and computes every gate's 8-bit selector table into a shadow bank. It then swaps shadow tables and masks into the active bank only during a precharge cycle, so the evaluate-phase logic never sees a table change mid-evaluation. It sits between the mask PRNG and the LMDPL gate array.

## Interface
- `N_GATES`, default 4: number of gates served; must be ≥1.
- `MASK_W`, default 4: mask stream beat width; `3*N_GATES` must be an integer multiple of `MASK_W`. `BEATS = 3*N_GATES/MASK_W`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mask_valid` input 1: a mask beat is present.
- `mask_data` input `MASK_W`: mask beat.
- `mask_ready` output 1: block accepts a beat this cycle.
- `tt` input `4*N_GATES`: per-gate truth table. Gate g uses `tt[4g+3:4g]`; bit index `{b,a}` gives F(a,b). Examples: NAND = 4'h7, AND = 4'h8, XOR = 4'h6.
- `pre` input 1: precharge phase indicator; swaps are permitted only when this is high.
- `flush` input 1: synchronous discard of the pending fill and shadow bank.
- `t_out` output `8*N_GATES`: active tables, gate g in `[8g+7:8g]`.
- `m_out` output `3*N_GATES`: active masks, gate g in `[3g+2:3g]` = `{m_out, m_in1, m_in0}`.
- `t_valid` output 1: the active bank holds a computed table set.
- `swap_cnt` output 16: number of swaps performed; wraps from 0xFFFF to 0.

## Operation
- **Mask vector:** the mask vector is `3*N_GATES` bits. Beat k fills bits `[MASK_W*(k+1)-1 : MASK_W*k]`, so beat 0 is least significant.
- **Table rule (gate g, j = 0..7):** with a = m_in0 ^ j[0] and b = m_in1 ^ j[1], `t[j] = ~F(a,b) ^ m_out ^ j[2]`. For NAND with masks 000 this gives 0x78.
- **State FILL:**
  - `mask_ready` = 1.
  - Each `mask_valid & mask_ready` stores the beat and increments the beat counter.
  - The beat that brings the counter to `BEATS` moves the block to CALC and resets the counter to 0.
- **State CALC (exactly one cycle):**
  - `mask_ready` = 0.
  - `tt` is sampled in this cycle.
  - Shadow tables for all gates are registered at the end of the cycle; the shadow masks are the collected vector.
  - Next state is WAIT.
- **State WAIT:**
  - `mask_ready` = 0.
  - On an edge with `pre` = 1, the block copies shadow to active (`t_out`, `m_out`), sets `t_valid` = 1, increments `swap_cnt`, and returns to FILL.
  - While `pre` = 0, the block stays in WAIT.
- **`pre` outside WAIT:** `pre` is ignored in FILL and CALC.
- **`flush` = 1:**
  - Next state is FILL, the beat counter and partial mask vector are cleared, and the shadow bank is invalidated.
  - The active bank, `t_valid` and `swap_cnt` are unchanged.
  - `flush` has priority over beat acceptance and over a swap in the same cycle.
  - A beat offered while `flush` = 1 is not counted, and `mask_ready` is still 1 if the state is FILL.
- **`tt` changes:** a change outside CALC has no effect until the next CALC.

## Timing
- **Reset values:** state = FILL, beat counter = 0, `t_out` = 0, `m_out` = 0, shadow bank = 0, `t_valid` = 0, `swap_cnt` = 0. `mask_ready` = 1 one cycle after deassertion, and combinationally from state.
- **Reset mid-operation:** reset in any state discards everything above; no partial vector survives.
- **Minimum latency:** with the last beat accepted at edge E, CALC occupies cycle E→E+1 and WAIT starts at E+1. The earliest swap is edge E+2 with `pre` = 1, so `t_out` changes two edges after the last beat.
- **Outputs:** `t_out`, `m_out`, `t_valid` and `swap_cnt` are registers with no combinational path from inputs. `t_out` and `m_out` change on the same edge.
- **Throughput:** at most one swap per `BEATS` + 2 cycles.
- **`mask_valid`:** may drop between beats; partial fills are held indefinitely.

## Test plan
Bench configuration: `N_GATES` = 4, `MASK_W` = 4, 3 beats.
- **NAND, zero masks:** reset, `tt` = 0x7777, beats 0x0, 0x0, 0x0, `pre` = 1 → two edges after the last beat, `t_out` = 0x78787878, `m_out` = 0x000, `t_valid` = 1, `swap_cnt` = 1.
- **NAND, mixed masks:** `tt` = 0x7777, beats 0x9, 0x5, 0xF (masks 001/011/101/111) → `t_out` = 0x1E4BE1B4, `m_out` = 0xF59.
- **Mixed functions:** `tt` = 0x8766 (XOR, XOR, NAND, AND), masks 0 → `t_out` = 0x87786969.
- **Held precharge:** `pre` held 0 for 10 cycles after CALC → state stays WAIT, `mask_ready` = 0, `t_out` unchanged. Raise `pre` → swap on the next edge, `swap_cnt` increments by exactly 1.
- **Reset mid-fill:** assert `rst` after 2 beats → all outputs 0 immediately. Next swap requires 3 fresh beats, and the masks reflect only those beats.
- **Flush in WAIT:** `flush` asserted in WAIT with `pre` = 1 in the same cycle → no swap, the previous `t_out` and `swap_cnt` are retained, the state is FILL, and 3 new beats are required.

Source files
------------

// File: rtl/lmdpl_tablegen_array.sv
// Selector-table generator for a bank of masked 2-input LMDPL gates: collects
// fresh masks, builds shadow tables, and swaps them into the active bank only during precharge.
module lmdpl_tablegen_array #(
  parameter int N_GATES = 4,
  parameter int MASK_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mask_valid,
  input  logic [MASK_W-1:0]      mask_data,
  output logic                   mask_ready,
  input  logic [4*N_GATES-1:0]   tt,
  input  logic                   pre,
  input  logic                   flush,
  output logic [8*N_GATES-1:0]   t_out,
  output logic [3*N_GATES-1:0]   m_out,
  output logic                   t_valid,
  output logic [15:0]            swap_cnt,
  output logic [1:0]             state_dbg
);
  localparam int VW    = 3 * N_GATES;
  localparam int BEATS = VW / MASK_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Mask stream handshake: a beat transfers on an edge where mask_valid and mask_ready are both high.
  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_CALC = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [VW-1:0]        vec_q, vec_d;
  logic [8*N_GATES-1:0] sh_t_q, sh_t_d;
  logic [VW-1:0]        sh_m_q, sh_m_d;
  logic [8*N_GATES-1:0] t_q, t_d;
  logic [VW-1:0]        m_q, m_d;
  logic                 valid_q, valid_d;
  logic [15:0]          cnt_q, cnt_d;

  // Entry j is the complemented gate output for masked inputs, re-masked by m_out and the j[2] rail.
  function automatic logic [7:0] gate_table(input logic [3:0] f, input logic [2:0] m);
    logic [7:0] t;
    logic       a, b;
    t = '0;
    for (int j = 0; j < 8; j++) begin
      a    = m[0] ^ j[0];
      b    = m[1] ^ j[1];
      t[j] = ~f[{b, a}] ^ m[2] ^ j[2];
    end
    return t;
  endfunction

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    vec_d      = vec_q;
    sh_t_d     = sh_t_q;
    sh_m_d     = sh_m_q;
    t_d        = t_q;
    m_d        = m_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    mask_ready = (state_q == S_FILL);

    if (flush) begin
      state_d = S_FILL;
      beat_d  = '0;
      vec_d   = '0;
      sh_t_d  = '0;
      sh_m_d  = '0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (mask_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_q == BW'(k)) vec_d[k*MASK_W +: MASK_W] = mask_data;
            end
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = S_CALC;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        S_CALC: begin
          for (int g = 0; g < N_GATES; g++) begin
            sh_t_d[8*g +: 8] = gate_table(tt[4*g +: 4], vec_q[3*g +: 3]);
          end
          sh_m_d  = vec_q;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (pre) begin
            t_d     = sh_t_q;
            m_d     = sh_m_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      beat_q  <= '0;
      vec_q   <= '0;
      sh_t_q  <= '0;
      sh_m_q  <= '0;
      t_q     <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vec_q   <= vec_d;
      sh_t_q  <= sh_t_d;
      sh_m_q  <= sh_m_d;
      t_q     <= t_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t_out     = t_q;
  assign m_out     = m_q;
  assign t_valid   = valid_q;
  assign swap_cnt  = cnt_q;
  assign state_dbg = state_q;
endmodule
